// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence blocks: state encoding used by both
// the pattern generator and the detector, plus a counter-width helper.
package seq_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_GAP   = S_GAP
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Loadable parallel-in / serial-out shift register, MSB first, zero fill.
module seq_piso_shreg #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [DW-1:0] i_din,
    output logic          o_msb
);

    logic [DW-1:0] shreg_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            shreg_reg <= '0;
        end else if (i_load) begin
            shreg_reg <= i_din;
        end else if (i_shift) begin
            shreg_reg <= {shreg_reg[DW-2:0], 1'b0};
        end
    end

    assign o_msb = shreg_reg[DW-1];

endmodule

// File: rtl/seq_gen_moore.sv
// Moore serial pattern generator: accepts a DW-bit word, emits it MSB first with an
// idle gap afterwards. Define SEQ_GEN_PARITY_EN to append an even-parity bit to each word.
module seq_gen_moore
    import seq_pkg::*;
#(
    parameter int DW      = 8,
    parameter int GAP_CYC = 2
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_seq,
    output logic          o_seq_vld,
    output logic          o_busy,
    output logic          o_done
);

    localparam int BW = cnt_width(DW + 1);
    localparam int GW = cnt_width(GAP_CYC + 1);

`ifdef SEQ_GEN_PARITY_EN
    // One extra payload slot: the parity bit goes out when the counter reaches zero.
    localparam logic [BW-1:0] BIT_LOAD = BW'(DW);
`else
    localparam logic [BW-1:0] BIT_LOAD = BW'(DW - 1);
`endif
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t          state_reg, state_next;
    logic [BW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            done_reg, done_next;
    logic            load, shift_en;
    logic            shreg_msb;
    logic            payload_bit;

    seq_piso_shreg #(
        .DW (DW)
    ) u_shreg (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_load  (load),
        .i_shift (shift_en),
        .i_din   (i_data),
        .o_msb   (shreg_msb)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        done_next    = 1'b0;
        load         = 1'b0;
        shift_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_valid) begin
                    load         = 1'b1;
                    bit_cnt_next = BIT_LOAD;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Shifting every cycle leaves the register zeroed at word end.
                shift_en = 1'b1;
                if (bit_cnt_reg == '0) begin
                    done_next = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_next   = ST_GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - BW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef SEQ_GEN_PARITY_EN
    logic parity_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            parity_reg <= 1'b0;
        end else if (load) begin
            parity_reg <= ^i_data;
        end
    end

    assign payload_bit = (bit_cnt_reg == '0) ? parity_reg : shreg_msb;
`else
    assign payload_bit = shreg_msb;
`endif

    // Outputs decode registered state only, so there is no input-to-output path.
    assign o_ready   = (state_reg == ST_IDLE);
    assign o_busy    = (state_reg != ST_IDLE);
    assign o_seq_vld = (state_reg == ST_SHIFT);
    assign o_seq     = (state_reg == ST_SHIFT) && payload_bit;
    assign o_done    = done_reg;

endmodule

// File: tb/tb_seq_gen_moore.sv
// Bench for seq_gen_moore: two instances (GAP_CYC=2 and GAP_CYC=0) checked cycle by
// cycle against a queue of expected serial bits.
module tb_seq_gen_moore;

    localparam int DW    = 8;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = DW + PB;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          valid_a = 1'b0, valid_b = 1'b0;
    logic          ready_a, seq_a, vld_a, busy_a, done_a;
    logic          ready_b, seq_b, vld_b, busy_b, done_b;

    int checks = 0;
    int failures = 0;
    bit sel = 1'b0;
    bit exp_q[$];

    always #5 clk = ~clk;

    seq_gen_moore #(.DW(DW), .GAP_CYC(GAP_A)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_data(data_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_seq(seq_a), .o_seq_vld(vld_a), .o_busy(busy_a), .o_done(done_a)
    );

    seq_gen_moore #(.DW(DW), .GAP_CYC(GAP_B)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_seq(seq_b), .o_seq_vld(vld_b), .o_busy(busy_b), .o_done(done_b)
    );

    // {ready, seq, seq_vld, busy, done}
    wire [4:0] st_a = {ready_a, seq_a, vld_a, busy_a, done_a};
    wire [4:0] st_b = {ready_b, seq_b, vld_b, busy_b, done_b};
    wire [4:0] st   = sel ? st_b : st_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic v);
        if (sel) begin
            data_b  = d;
            valid_b = v;
        end else begin
            data_a  = d;
            valid_a = v;
        end
    endtask

    task automatic accept(input logic [DW-1:0] d, input string tag);
        checks++;
        if (st[4] !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, st[4]);
        end
        drive(d, 1'b1);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
        if (PB != 0) exp_q.push_back(^d);
        tick();
    endtask

    task automatic watch_word(input int gap, input bit scramble, input string tag);
        int  last;
        bit  e_vld, e_done, e_busy, e_rdy, e_seq;
        last = L + gap + 1;
        for (int c = 1; c <= last; c++) begin
            e_vld  = (c <= L);
            e_done = (c == L + 1);
            e_busy = (c <= L + gap);
            e_rdy  = !e_busy;
            e_seq  = 1'b0;
            if (e_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s scoreboard_empty at cycle %0d: got size 0 want >0", tag, c);
                end else begin
                    e_seq = exp_q.pop_front();
                end
            end
            checks++;
            if (st !== {e_rdy, e_seq, e_vld, e_busy, e_done}) begin
                failures++;
                $display("FAIL %s cycle %0d rdy/seq/vld/busy/done: got %b want %b",
                         tag, c, st, {e_rdy, e_seq, e_vld, e_busy, e_done});
            end
            if (c < last) begin
                if (scramble) drive(DW'($urandom_range(0, 255)), 1'b1);
                tick();
            end
        end
        $display("word %s gap=%0d complete", tag, gap);
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        data_a  = 8'hC3;
        data_b  = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st_a !== 5'b10000) begin
                failures++;
                $display("FAIL reset_a cycle %0d: got %b want 10000", i, st_a);
            end
            checks++;
            if (st_b !== 5'b10000) begin
                failures++;
                $display("FAIL reset_b cycle %0d: got %b want 10000", i, st_b);
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        rstn    = 1'b1;
        tick();
        $display("reset sequence complete");
    endtask

    task automatic test_single();
        sel = 1'b0;
        accept(8'hB4, "single_b4");
        drive(8'h00, 1'b0);
        watch_word(GAP_A, 1'b0, "single_b4");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        accept(8'hFF, "b2b_ff");
        watch_word(GAP_A, 1'b1, "b2b_ff");
        accept(8'h01, "b2b_01");
        drive(8'h00, 1'b0);
        watch_word(GAP_A, 1'b0, "b2b_01");
    endtask

    task automatic test_gap0();
        sel = 1'b1;
        accept(8'h81, "gap0_81");
        drive(8'h00, 1'b0);
        watch_word(GAP_B, 1'b0, "gap0_81");
        accept(8'h3C, "gap0_3c");
        drive(8'h00, 1'b0);
        watch_word(GAP_B, 1'b0, "gap0_3c");
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit e_seq;
        sel = 1'b0;
        accept(8'hAA, "mid_aa");
        drive(8'h00, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            e_seq = exp_q.pop_front();
            checks++;
            if (st !== {1'b0, e_seq, 1'b1, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL mid_aa cycle %0d: got %b want %b", c, st, {1'b0, e_seq, 3'b110});
            end
            if (c < 4) tick();
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (st_a !== 5'b10000) begin
            failures++;
            $display("FAIL mid_async_clear: got %b want 10000", st_a);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st_a !== 5'b10000) begin
                failures++;
                $display("FAIL mid_hold cycle %0d: got %b want 10000", i, st_a);
            end
        end
        rstn = 1'b1;
        tick();
        $display("word mid_aa aborted by reset");
        accept(8'h55, "post_reset_55");
        drive(8'h00, 1'b0);
        watch_word(GAP_A, 1'b0, "post_reset_55");
    endtask

    task automatic test_patterns();
        logic [DW-1:0] words [4];
        words[0] = 8'hB4;
        words[1] = 8'h07;
        words[2] = 8'h5A;
        words[3] = DW'($urandom_range(0, 255));
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            accept(words[i], $sformatf("pat_%02h", words[i]));
            drive(8'h00, 1'b0);
            watch_word(GAP_A, 1'b0, $sformatf("pat_%02h", words[i]));
        end
        sel = 1'b1;
        accept(8'h07, "pat0_07");
        drive(8'h00, 1'b0);
        watch_word(GAP_B, 1'b0, "pat0_07");
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap0();
        test_reset_mid();
        test_patterns();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
